// File: rtl/fetch_pkg.sv
// Shared state encoding, constants and helpers for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

  localparam int unsigned BUBBLE_INSTR = 32'd0;
  localparam int unsigned PC_INC       = 32'd4;

  // Saturating increment for the optional performance counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction or squash to a bubble.
module if_id_reg #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic               valid_o
);
  import fetch_pkg::*;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;

  // A squash wins over a load; the PC field is left as-is for a bubble.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush_i) begin
      instr_d = INSTR_W'(BUBBLE_INSTR);
      valid_d = 1'b0;
    end else if (load_i) begin
      pc_d    = pc_i;
      instr_d = instr_i;
      valid_d = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // IF/ID storage.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q    <= {ADDR_W{1'b0}};
      instr_q <= {INSTR_W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem request handshake and IF/ID register.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               PCWrite_i,
  input  logic               IF_ID_Write_i,
  input  logic               mem_stall_i,
  input  logic               Flush_i,
  input  logic [ADDR_W-1:0]  Branch_target_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic [ADDR_W-1:0]  IF_ID_PC_o,
  output logic [INSTR_W-1:0] IF_ID_instr_o,
  output logic               IF_ID_valid_o,
  output logic [ADDR_W-1:0]  pc_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_cnt_o,
  output logic [31:0]        stall_cnt_o,
  output logic [31:0]        flush_cnt_o
`endif
);
  import fetch_pkg::*;

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               req_q, req_d;
  logic [INSTR_W-1:0] buf_q, buf_d;

  logic               adv_s, redirect_s;
  logic [ADDR_W-1:0]  pc_inc_s, drop_pc_s;
  logic               ifid_load_s, ifid_flush_s;
  logic [ADDR_W-1:0]  ifid_pc_s;
  logic [INSTR_W-1:0] ifid_instr_s;

  assign adv_s      = IF_ID_Write_i & PCWrite_i & ~mem_stall_i;
  assign redirect_s = Flush_i & IF_ID_Write_i & ~mem_stall_i;
  assign pc_inc_s   = pc_q + ADDR_W'(PC_INC);
  assign drop_pc_s  = redirect_s ? Branch_target_i : pc_q;

  // Next-state logic. In FETCH the PC always equals the outstanding request address.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    req_d        = req_q;
    buf_d        = buf_q;
    ifid_load_s  = 1'b0;
    ifid_flush_s = 1'b0;
    ifid_pc_s    = pc_q;
    ifid_instr_s = imem_data_i;
    case (state_q)
      IDLE: begin
        if (start_i && !mem_stall_i) begin
          state_d = FETCH;
          req_d   = 1'b1;
          addr_d  = pc_q;
        end else begin
          req_d = 1'b0;
        end
      end
      FETCH: begin
        if (mem_stall_i) begin
          // Stalled pipeline still absorbs a returning fetch.
          if (imem_ack_i) begin
            buf_d   = imem_data_i;
            req_d   = 1'b0;
            state_d = HOLD;
          end else begin
            req_d = 1'b1;
          end
        end else if (redirect_s) begin
          ifid_flush_s = 1'b1;
          pc_d         = Branch_target_i;
          if (imem_ack_i) begin
            addr_d = Branch_target_i;
          end else begin
            state_d = DROP;
          end
        end else if (imem_ack_i) begin
          if (adv_s) begin
            ifid_load_s = 1'b1;
            pc_d        = pc_inc_s;
            addr_d      = pc_inc_s;
          end else begin
            buf_d   = imem_data_i;
            req_d   = 1'b0;
            state_d = HOLD;
          end
        end else if (adv_s) begin
          ifid_flush_s = 1'b1;
        end else begin
          req_d = 1'b1;
        end
      end
      HOLD: begin
        if (mem_stall_i) begin
          req_d = 1'b0;
        end else if (redirect_s) begin
          ifid_flush_s = 1'b1;
          pc_d         = Branch_target_i;
          addr_d       = Branch_target_i;
          req_d        = 1'b1;
          state_d      = FETCH;
        end else if (adv_s) begin
          ifid_load_s  = 1'b1;
          ifid_instr_s = buf_q;
          pc_d         = pc_inc_s;
          addr_d       = pc_inc_s;
          req_d        = 1'b1;
          state_d      = FETCH;
        end else begin
          req_d = 1'b0;
        end
      end
      DROP: begin
        pc_d = drop_pc_s;
        if (imem_ack_i) begin
          addr_d  = drop_pc_s;
          state_d = FETCH;
        end else begin
          addr_d = addr_q;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Fetch control state; outputs come straight from these flops.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      buf_q   <= {INSTR_W{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      buf_q   <= buf_d;
    end
  end

  if_id_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_if_id (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (ifid_load_s),
    .flush_i (ifid_flush_s),
    .pc_i    (ifid_pc_s),
    .instr_i (ifid_instr_s),
    .pc_o    (IF_ID_PC_o),
    .instr_o (IF_ID_instr_o),
    .valid_o (IF_ID_valid_o)
  );

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;
  assign pc_o        = pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Event counting; nothing is counted before fetching starts.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (ifid_load_s) begin
      fetch_cnt_d = sat_inc(fetch_cnt_q);
    end else begin
      fetch_cnt_d = fetch_cnt_q;
    end
    if ((state_q != IDLE) && !adv_s) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if ((state_q != IDLE) && redirect_s) begin
      flush_cnt_d = sat_inc(flush_cnt_q);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Counter storage.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
